// File: rtl/alu_sequencer.sv
// alu_sequencer: paces control words from a writable program memory
// into the ALU datapath on a divided clock-enable, and captures results.
// Ports: external_clk, reset (sync, active-low); mode/start/stop/step
// run control; load_we/load_addr/load_data program writes; alu_result
// datapath result in; tick, ctrl_word, ctrl_valid, pc, last_result,
// checksum, wrap_count, busy, done status out (all registered).
module alu_sequencer #(
    parameter int WORD_W = 17,
    parameter int DEPTH = 16,
    parameter int RESULT_W = 16,
    parameter int DIV = 10,
    parameter logic [WORD_W-1:0] INIT_WORD = 17'h12E1F,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                external_clk,
    input  logic                reset,
    input  logic [1:0]          mode,
    input  logic                start,
    input  logic                stop,
    input  logic                step,
    input  logic                load_we,
    input  logic [AW-1:0]       load_addr,
    input  logic [WORD_W-1:0]   load_data,
    input  logic [RESULT_W-1:0] alu_result,
    output logic                tick,
    output logic [WORD_W-1:0]   ctrl_word,
    output logic                ctrl_valid,
    output logic [AW-1:0]       pc,
    output logic [RESULT_W-1:0] last_result,
    output logic [RESULT_W-1:0] checksum,
    output logic [7:0]          wrap_count,
    output logic                busy,
    output logic                done
);

    localparam int CW = $clog2(DIV + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV);
    localparam logic [AW-1:0] PC_LAST = AW'(DEPTH - 1);

    localparam logic [1:0] M_ONE  = 2'b01;
    localparam logic [1:0] M_STEP = 2'b10;
    localparam logic [1:0] M_RSVD = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_RUN,
        S_STEP,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          mode_q, mode_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                tick_q, tick_d;
    logic [WORD_W-1:0]   ctrl_word_q, ctrl_word_d;
    logic                ctrl_valid_q, ctrl_valid_d;
    logic [AW-1:0]       pc_q, pc_d;
    logic [RESULT_W-1:0] last_result_q, last_result_d;
    logic [RESULT_W-1:0] checksum_q, checksum_d;
    logic [7:0]          wrap_q, wrap_d;
    logic                pending_q, pending_d;
    logic                step_req_q, step_req_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [WORD_W-1:0]   mem_q [DEPTH];

    // Program memory: no reset, writable only while no run is active.
    always_ff @(posedge external_clk) begin
        if (reset && load_we &&
            (state_q == S_IDLE || state_q == S_DONE)) begin
            mem_q[load_addr] <= load_data;
        end
    end

    always_comb begin
        cnt_d         = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
        // Everything "on tick" happens on the edge that enters the
        // tick cycle, so ctrl_valid lines up with tick.
        tick_d        = (cnt_d == CNT_MAX);
        state_d       = state_q;
        mode_d        = mode_q;
        ctrl_word_d   = ctrl_word_q;
        ctrl_valid_d  = 1'b0;
        pc_d          = pc_q;
        last_result_d = last_result_q;
        checksum_d    = checksum_q;
        wrap_d        = wrap_q;
        pending_d     = pending_q;
        step_req_d    = step_req_q;

        if (stop && state_q != S_IDLE) begin
            state_d    = S_IDLE;
            pending_d  = 1'b0;
            step_req_d = 1'b0;
            pc_d       = '0;
        end else begin
            if (tick_d && pending_q) begin
                last_result_d = alu_result;
                checksum_d    = checksum_q + alu_result;
                pending_d     = 1'b0;
            end
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (start && !stop && mode != M_RSVD) begin
                        state_d    = S_INIT;
                        mode_d     = mode;
                        checksum_d = '0;
                        wrap_d     = '0;
                    end
                end
                S_INIT: begin
                    if (tick_d) begin
                        ctrl_word_d  = INIT_WORD;
                        ctrl_valid_d = 1'b1;
                        pending_d    = 1'b1;
                        pc_d         = '0;
                        state_d      = (mode_q == M_STEP) ? S_STEP : S_RUN;
                    end
                end
                S_RUN: begin
                    if (tick_d) begin
                        ctrl_word_d  = mem_q[pc_q];
                        ctrl_valid_d = 1'b1;
                        pending_d    = 1'b1;
                        pc_d         = pc_q + 1'b1;
                        if (pc_q == PC_LAST) begin
                            if (mode_q == M_ONE) begin
                                state_d = S_DONE;
                            end else begin
                                wrap_d = wrap_q + 8'd1;
                            end
                        end
                    end
                end
                S_STEP: begin
                    if (tick_d && step_req_q) begin
                        ctrl_word_d  = mem_q[pc_q];
                        ctrl_valid_d = 1'b1;
                        pending_d    = 1'b1;
                        pc_d         = pc_q + 1'b1;
                        step_req_d   = 1'b0;
                        if (pc_q == PC_LAST) begin
                            wrap_d = wrap_q + 8'd1;
                        end
                    end
                    // A pulse on the service edge counts as a new request.
                    if (step) begin
                        step_req_d = 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE) && !pending_d;
    end

    always_ff @(posedge external_clk) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            mode_q        <= '0;
            cnt_q         <= '0;
            tick_q        <= 1'b0;
            ctrl_word_q   <= '0;
            ctrl_valid_q  <= 1'b0;
            pc_q          <= '0;
            last_result_q <= '0;
            checksum_q    <= '0;
            wrap_q        <= '0;
            pending_q     <= 1'b0;
            step_req_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            cnt_q         <= cnt_d;
            tick_q        <= tick_d;
            ctrl_word_q   <= ctrl_word_d;
            ctrl_valid_q  <= ctrl_valid_d;
            pc_q          <= pc_d;
            last_result_q <= last_result_d;
            checksum_q    <= checksum_d;
            wrap_q        <= wrap_d;
            pending_q     <= pending_d;
            step_req_q    <= step_req_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign tick        = tick_q;
    assign ctrl_word   = ctrl_word_q;
    assign ctrl_valid  = ctrl_valid_q;
    assign pc          = pc_q;
    assign last_result = last_result_q;
    assign checksum    = checksum_q;
    assign wrap_count  = wrap_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule
